// File: rtl/fft_stage1_seq.sv
// rtl/fft_stage1_seq.sv - sequential first radix-2 DIT stage (W^0) over a bit-reversed sample store
//
// Purpose: samples are written in natural order through an addressed load port
// and stored at bit-reversed addresses. A start kicks off one butterfly per
// cycle over adjacent memory pairs, writing sum/difference into the
// flattened output buses. Results are either halved or saturated.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   load      write strobe for xr_in/xi_in at addr_in (IDLE/DONE only)
//   addr_in   natural-order sample index
//   xr_in     signed real sample
//   xi_in     signed imaginary sample
//   start     begin a run (IDLE/DONE, and only when load is low)
//   scale_en  1 = halve each result, 0 = saturate; captured at start
//   busy      high while butterflies are being computed
//   done      one-cycle pulse after the last butterfly is written
//   ovf       sticky saturation flag for the current run
//   st1_yr    real outputs, slot i at [i*W +: W]
//   st1_yi    imaginary outputs, same packing
module fft_stage1_seq #(
  parameter int N    = 16,
  parameter int LOGN = 4,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LOGN-1:0]     addr_in,
  input  logic signed [W-1:0] xr_in,
  input  logic signed [W-1:0] xi_in,
  input  logic                start,
  input  logic                scale_en,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [N*W-1:0]      st1_yr,
  output logic [N*W-1:0]      st1_yi
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LOGN-2:0] K_ONE = 1;

  state_t state, state_nx;
  logic [LOGN-2:0]     k;
  logic                scale_q;
  logic signed [W-1:0] mem_r [N];
  logic signed [W-1:0] mem_i [N];

  logic            load_ok, start_ok, last;
  logic [LOGN-1:0] ia, ib;
  logic [W:0]      ar, br, ai, bi;
  logic [W:0]      sr, dr, si, di;
  logic [W:0]      fr0, fr1, fi0, fi1;
  logic            clip;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  // Returns {clipped, value}. Halving keeps the upper W bits of the W+1-bit
  // result (floor); saturation detects overflow when the top two bits differ.
  function automatic logic [W:0] fit(input logic [W:0] s, input logic sc);
    logic [W:0] r;
    if (sc)
      r = {1'b0, s[W:1]};
    else if (s[W] != s[W-1])
      r = {1'b1, s[W], {(W-1){~s[W]}}};
    else
      r = {1'b0, s[W-1:0]};
    return r;
  endfunction

  assign busy = (state == RUN);
  assign last = (k == '1);
  assign ia   = {k, 1'b0};
  assign ib   = {k, 1'b1};

  assign ar = {mem_r[ia][W-1], mem_r[ia]};
  assign br = {mem_r[ib][W-1], mem_r[ib]};
  assign ai = {mem_i[ia][W-1], mem_i[ia]};
  assign bi = {mem_i[ib][W-1], mem_i[ib]};
  assign sr = ar + br;
  assign dr = ar - br;
  assign si = ai + bi;
  assign di = ai - bi;

  assign fr0  = fit(sr, scale_q);
  assign fr1  = fit(dr, scale_q);
  assign fi0  = fit(si, scale_q);
  assign fi1  = fit(di, scale_q);
  assign clip = fr0[W] | fr1[W] | fi0[W] | fi1[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Load has priority over start so a simultaneous pair never races a
  // half-written sample into a run.
  always_comb begin
    state_nx = state;
    load_ok  = 1'b0;
    start_ok = 1'b0;
    case (state)
      IDLE, DONE: begin
        load_ok = load;
        if (start && !load) begin
          start_ok = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      scale_q <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      st1_yr  <= '0;
      st1_yi  <= '0;
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '0;
        mem_i[i] <= '0;
      end
    end else begin
      done <= (state == RUN) && last;
      if (load_ok) begin
        mem_r[bitrev(addr_in)] <= xr_in;
        mem_i[bitrev(addr_in)] <= xi_in;
      end
      if (start_ok) begin
        k       <= '0;
        scale_q <= scale_en;
        ovf     <= 1'b0;
      end else if (state == RUN) begin
        // k wraps to zero on the last pair, ready for the next run
        k <= k + K_ONE;
        st1_yr[(2*int'(k))*W +: W]   <= fr0[W-1:0];
        st1_yr[(2*int'(k)+1)*W +: W] <= fr1[W-1:0];
        st1_yi[(2*int'(k))*W +: W]   <= fi0[W-1:0];
        st1_yi[(2*int'(k)+1)*W +: W] <= fi1[W-1:0];
        if (clip) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_stage1_seq.sv
// tb/tb_fft_stage1_seq.sv - self-checking bench for fft_stage1_seq (N=16/W=16 and N=8/W=12)
module tb_fft_stage1_seq;

  localparam int N = 16;
  localparam int LOGN = 4;
  localparam int W = 16;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              load = 1'b0, start = 1'b0, scale_en = 1'b0;
  logic [LOGN-1:0]   addr_in = '0;
  logic [W-1:0]      xr_in = '0, xi_in = '0;
  logic              busy, done, ovf;
  logic [N*W-1:0]    st1_yr, st1_yi;

  logic              load8 = 1'b0, start8 = 1'b0, scale8 = 1'b0;
  logic [2:0]        addr8 = '0;
  logic [11:0]       xr8 = '0, xi8 = '0;
  logic              busy8, done8, ovf8;
  logic [95:0]       yr8, yi8;

  fft_stage1_seq #(.N(N), .LOGN(LOGN), .W(W)) dut (
    .clk(clk), .rst(rst), .load(load), .addr_in(addr_in), .xr_in(xr_in), .xi_in(xi_in),
    .start(start), .scale_en(scale_en), .busy(busy), .done(done), .ovf(ovf),
    .st1_yr(st1_yr), .st1_yi(st1_yi)
  );

  fft_stage1_seq #(.N(8), .LOGN(3), .W(12)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .addr_in(addr8), .xr_in(xr8), .xi_in(xi8),
    .start(start8), .scale_en(scale8), .busy(busy8), .done(done8), .ovf(ovf8),
    .st1_yr(yr8), .st1_yi(yi8)
  );

  int checks = 0;
  int errors = 0;

  // natural-order sample store and expected results
  int x_r[N], x_i[N], er[N], ei[N];
  bit eov;

  typedef struct {
    int mode;  // 0 ramp, 1 positive clip, 2 subtraction clip
    bit sc;
    int idx;
    int yr;
    int yi;
    bit ov;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int yr(input int i);
    return int'($signed(st1_yr[i*W +: W]));
  endfunction

  function automatic int yi(input int i);
    return int'($signed(st1_yi[i*W +: W]));
  endfunction

  function automatic int brv(input int j);
    int r = 0;
    for (int b = 0; b < LOGN; b++)
      if (((j >> b) & 1) != 0) r += 1 << (LOGN - 1 - b);
    return r;
  endfunction

  function automatic int fitm(input int s, input bit sc, inout bit ov);
    if (sc) return s >>> 1;
    if (s > MAXV) begin ov = 1'b1; return MAXV; end
    if (s < MINV) begin ov = 1'b1; return MINV; end
    return s;
  endfunction

  // y[2k] / y[2k+1] combine the samples whose indices bit-reverse to 2k, 2k+1
  task automatic model_run(input bit sc);
    eov = 1'b0;
    for (int k = 0; k < N / 2; k++) begin
      int a0, a1;
      a0 = brv(2 * k);
      a1 = brv(2 * k + 1);
      er[2*k]   = fitm(x_r[a0] + x_r[a1], sc, eov);
      er[2*k+1] = fitm(x_r[a0] - x_r[a1], sc, eov);
      ei[2*k]   = fitm(x_i[a0] + x_i[a1], sc, eov);
      ei[2*k+1] = fitm(x_i[a0] - x_i[a1], sc, eov);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin x_r[i] = i; x_i[i] = 0; end
        1: begin x_r[i] = MAXV; x_i[i] = MINV; end
        default: begin x_r[i] = 0; x_i[i] = 0; end
      endcase
    end
    if (mode == 2) begin
      x_r[0] = MINV;
      x_r[8] = MAXV;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      logic [15:0] t, u;
      t = 16'($urandom);
      u = 16'($urandom);
      if ($urandom_range(0, 3) == 0) t = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
      if ($urandom_range(0, 3) == 0) u = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
      x_r[i] = int'($signed(t));
      x_i[i] = int'($signed(u));
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      load = 1'b1;
      addr_in = LOGN'(i);
      xr_in = W'(x_r[i]);
      xi_in = W'(x_i[i]);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  // Runs once from a negedge; optional disturbances during RUN: a load with
  // random data, a second start, and a flip of scale_en.
  task automatic do_run(input bit sc, input bit mid_load, input bit mid_start,
                        output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1;
    scale_en = sc;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
      if (c == 2) begin
        scale_en = ~sc;
        if (mid_load) begin
          load = 1'b1;
          addr_in = LOGN'($urandom);
          xr_in = W'($urandom);
          xi_in = W'($urandom);
        end
      end
      if (c == 3) begin
        load = 1'b0;
        if (mid_start) start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      @(negedge clk);
    end
    scale_en = sc;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s yr[%0d]", tag, i), yr(i), er[i]);
      chk($sformatf("%s yi[%0d]", tag, i), yi(i), ei[i]);
    end
    chk($sformatf("%s ovf", tag), int'(ovf), int'(eov));
  endtask

  task automatic run_and_check(input string tag, input bit sc, input bit ml, input bit ms);
    int bn, dn, da;
    do_run(sc, ml, ms, bn, dn, da);
    chk($sformatf("%s busy_cycles", tag), bn, N / 2);
    chk($sformatf("%s done_pulses", tag), dn, 1);
    chk($sformatf("%s done_cycle", tag), da, N / 2 + 1);
    model_run(sc);
    check_all(tag);
  endtask

  initial begin
    int bn, dn, da;
    int exp8[8];

    tbl[0]  = '{0, 1'b0, 0, 8, 0, 1'b0};
    tbl[1]  = '{0, 1'b0, 1, -8, 0, 1'b0};
    tbl[2]  = '{0, 1'b0, 2, 16, 0, 1'b0};
    tbl[3]  = '{0, 1'b0, 3, -8, 0, 1'b0};
    tbl[4]  = '{0, 1'b0, 14, 22, 0, 1'b0};
    tbl[5]  = '{0, 1'b0, 15, -8, 0, 1'b0};
    tbl[6]  = '{0, 1'b1, 0, 4, 0, 1'b0};
    tbl[7]  = '{0, 1'b1, 1, -4, 0, 1'b0};
    tbl[8]  = '{0, 1'b1, 2, 8, 0, 1'b0};
    tbl[9]  = '{0, 1'b1, 14, 11, 0, 1'b0};
    tbl[10] = '{0, 1'b1, 9, -4, 0, 1'b0};
    tbl[11] = '{1, 1'b0, 0, MAXV, MINV, 1'b1};
    tbl[12] = '{1, 1'b0, 1, 0, 0, 1'b1};
    tbl[13] = '{1, 1'b0, 6, MAXV, MINV, 1'b1};
    tbl[14] = '{2, 1'b0, 0, -1, 0, 1'b1};
    tbl[15] = '{2, 1'b0, 1, MINV, 0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst yr_zero", int'(st1_yr == '0), 1);
    chk("rst yi_zero", int'(st1_yi == '0), 1);
    rst = 1'b0;

    // table vectors: known values, independent of the model
    for (int v = 0; v < 16; v++) begin
      fill(tbl[v].mode);
      load_all();
      do_run(tbl[v].sc, 1'b0, 1'b0, bn, dn, da);
      chk($sformatf("tbl%0d done_cycle", v), da, N / 2 + 1);
      chk($sformatf("tbl%0d yr[%0d]", v, tbl[v].idx), yr(tbl[v].idx), tbl[v].yr);
      chk($sformatf("tbl%0d yi[%0d]", v, tbl[v].idx), yi(tbl[v].idx), tbl[v].yi);
      chk($sformatf("tbl%0d ovf", v), int'(ovf), int'(tbl[v].ov));
    end

    // random data, alternating scale mode, with disturbances during RUN
    for (int r = 0; r < 6; r++) begin
      fill_random();
      load_all();
      run_and_check($sformatf("rnd%0d", r), r[0], r == 2 || r == 4, r == 3 || r == 4);
      if (r == 2 || r == 4) run_and_check($sformatf("rerun%0d", r), r[0], 1'b0, 1'b0);
    end

    // start together with load: sample written, no run begins
    @(negedge clk);
    load = 1'b1; start = 1'b1; addr_in = 4'd5; xr_in = 16'd1234; xi_in = -16'sd77;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    x_r[5] = 1234; x_i[5] = -77;
    bn = 0;
    repeat (4) begin
      if (busy || done) bn++;
      @(negedge clk);
    end
    chk("start_load no_run", bn, 0);
    run_and_check("start_load", 1'b0, 1'b0, 1'b0);

    // reset asserted right after E4 aborts the run
    fill(0);
    load_all();
    @(negedge clk);
    start = 1'b1; scale_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst ovf", int'(ovf), 0);
    chk("midrst yr_zero", int'(st1_yr == '0), 1);
    chk("midrst yi_zero", int'(st1_yi == '0), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0; bn = 0;
    repeat (12) begin
      if (done) dn++;
      if (busy) bn++;
      @(negedge clk);
    end
    chk("midrst no_done", dn, 0);
    chk("midrst no_busy", bn, 0);
    fill(2);
    for (int i = 0; i < N; i++) begin x_r[i] = 0; x_i[i] = 0; end
    run_and_check("midrst zero_mem", 1'b0, 1'b0, 1'b0);
    fill(0);
    load_all();
    run_and_check("midrst reload", 1'b0, 1'b0, 1'b0);

    // N=8, W=12 ramp
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load8 = 1'b1; addr8 = 3'(i); xr8 = 12'(i); xi8 = '0;
    end
    @(negedge clk);
    load8 = 1'b0; scale8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bn = 0; dn = 0; da = -1;
    for (int c = 1; c <= 10; c++) begin
      if (busy8) bn++;
      if (done8) begin dn++; da = c; end
      @(negedge clk);
    end
    chk("n8 busy_cycles", bn, 4);
    chk("n8 done_cycle", da, 5);
    chk("n8 done_pulses", dn, 1);
    exp8 = '{4, -4, 8, -4, 6, -4, 10, -4};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("n8 yr[%0d]", i), int'($signed(yr8[i*12 +: 12])), exp8[i]);
      chk($sformatf("n8 yi[%0d]", i), int'($signed(yi8[i*12 +: 12])), 0);
    end
    chk("n8 ovf", int'(ovf8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
